// File: rtl/bilinear_interp_pipe_if.sv
// Handshake/data bundle for bilinear_interp_pipe: four neighbour pixels, weights,
// and valid/ready on both sides. The master drives inputs; the slave is the interpolator.
interface bilinear_interp_pipe_if #(
  parameter int PIX_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int CHANNELS = 1
);
  logic [CHANNELS*PIX_W-1:0] p00;
  logic [CHANNELS*PIX_W-1:0] p01;
  logic [CHANNELS*PIX_W-1:0] p10;
  logic [CHANNELS*PIX_W-1:0] p11;
  logic [FRAC_W:0]           fx;
  logic [FRAC_W:0]           fy;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*PIX_W-1:0] out_pix;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output p00, p01, p10, p11, fx, fy, in_valid, out_ready,
    input  in_ready, out_pix, out_valid
  );

  modport slave (
    input  p00, p01, p10, p11, fx, fy, in_valid, out_ready,
    output in_ready, out_pix, out_valid
  );
endinterface

// File: rtl/bilinear_interp_pipe.sv
// 3-stage bilinear interpolator: S1 horizontal lerp, S2 vertical lerp, S3 round/saturate.
// Define BILINEAR_ROUND_EN for round-half-up in S3; otherwise the fraction is truncated.
module bilinear_interp_pipe #(
  parameter int PIX_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int CHANNELS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bilinear_interp_pipe_if.slave  bus
);
  // TW holds any lerp result with FRAC_W fraction bits plus sign; PW holds the S2 product.
  localparam int TW = PIX_W + FRAC_W + 2;
  localparam int PW = TW + FRAC_W + 2;
  localparam logic [FRAC_W:0]          ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [TW-1:0]     HALF = {{(TW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [TW-1:0]     MAXV = {{(TW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic                      adv;
  logic                      v1_reg, v2_reg, v3_reg;
  logic [FRAC_W:0]           fxc, fyc;
  logic [FRAC_W:0]           fy1_reg;
  logic [CHANNELS*PIX_W-1:0] pix_all;

  assign adv           = !v3_reg || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_reg;
  assign bus.out_pix   = pix_all;

  assign fxc = (bus.fx > ONE) ? ONE : bus.fx;
  assign fyc = (bus.fy > ONE) ? ONE : bus.fy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      v3_reg  <= 1'b0;
      fy1_reg <= '0;
    end else if (adv) begin
      v1_reg  <= bus.in_valid;
      v2_reg  <= v1_reg;
      v3_reg  <= v2_reg;
      fy1_reg <= fyc;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [TW-1:0] a, b, c, d, fxs;
      logic signed [TW-1:0] top_next, bot_next, top_reg, bot_reg;
      logic signed [TW-1:0] diff, q_next, q_reg, s;
      logic signed [PW-1:0] diff_w, fys, prod;
      logic [PIX_W-1:0]     pix_next, pix_reg;

      assign a   = $signed({{(TW-PIX_W){1'b0}}, bus.p00[gi*PIX_W +: PIX_W]});
      assign b   = $signed({{(TW-PIX_W){1'b0}}, bus.p01[gi*PIX_W +: PIX_W]});
      assign c   = $signed({{(TW-PIX_W){1'b0}}, bus.p10[gi*PIX_W +: PIX_W]});
      assign d   = $signed({{(TW-PIX_W){1'b0}}, bus.p11[gi*PIX_W +: PIX_W]});
      assign fxs = $signed({{(TW-FRAC_W-1){1'b0}}, fxc});

      // Exact in TW: |(b-a)*fx| never exceeds (2^PIX_W-1) << FRAC_W.
      assign top_next = (a <<< FRAC_W) + (b - a) * fxs;
      assign bot_next = (c <<< FRAC_W) + (d - c) * fxs;

      assign diff   = bot_reg - top_reg;
      assign diff_w = $signed({{(PW-TW){diff[TW-1]}}, diff});
      assign fys    = $signed({{(PW-FRAC_W-1){1'b0}}, fy1_reg});
      assign prod   = diff_w * fys;
      assign q_next = top_reg + TW'(prod >>> FRAC_W);

`ifdef BILINEAR_ROUND_EN
      assign s = (q_reg + HALF) >>> FRAC_W;
`else
      assign s = q_reg >>> FRAC_W;
`endif

      always_comb begin
        pix_next = s[PIX_W-1:0];
        if (s[TW-1]) begin
          pix_next = '0;
        end else if (s > MAXV) begin
          pix_next = '1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          top_reg <= '0;
          bot_reg <= '0;
          q_reg   <= '0;
          pix_reg <= '0;
        end else if (adv) begin
          top_reg <= top_next;
          bot_reg <= bot_next;
          q_reg   <= q_next;
          pix_reg <= pix_next;
        end
      end

      assign pix_all[gi*PIX_W +: PIX_W] = pix_reg;
    end
  endgenerate
endmodule
